// File: rtl/xgmii_encoder.sv
// XGMII to 64b/66b block encoder.
// Two 32-bit XGMII words (lanes 0-3 then lanes 4-7) form one 8-lane block.
// The block is classified and encoded, a transmit sequence FSM checks it,
// and the result goes out as two 32-bit words with a 2-bit sync header
// attached to the first. Illegal blocks or illegal block orders are replaced
// by an error block, and o_encode_err pulses alongside its first word.
// The block layout is fixed at 64 bits, so DATA_WIDTH/CTRL_WIDTH must stay
// at their defaults.
module xgmii_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_xgmii_txd,
    input  logic [CTRL_WIDTH-1:0] i_xgmii_txc,
    input  logic                  i_xgmii_valid,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_data_valid,
    output logic [HDR_WIDTH-1:0]  o_tx_hdr,
    output logic                  o_tx_hdr_valid,
    output logic                  o_encode_err
);

    localparam int BLK_W = 2 * DATA_WIDTH;
    localparam int BLK_C = 2 * CTRL_WIDTH;

    // Block classes recognised on the transmit path.
    typedef enum logic [2:0] {
        CLS_D   = 3'd0,
        CLS_C   = 3'd1,
        CLS_S0  = 3'd2,
        CLS_S4  = 3'd3,
        CLS_T   = 3'd4,
        CLS_ERR = 3'd5
    } cls_t;

    // Transmit sequence states: in control, in data, after an error.
    typedef enum logic [1:0] {
        TX_C = 2'd0,
        TX_D = 2'd1,
        TX_E = 2'd2
    } tx_state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Bit k set when the block is a valid terminate with /T/ in lane k:
    // lane k = 0xFD, control flags set from lane k upward, idles above k.
    function automatic logic [7:0] term_lanes(input logic [63:0] txd,
                                              input logic [7:0]  txc);
        logic [7:0] hit;
        logic       ok;
        hit = 8'h00;
        for (int k = 0; k < 8; k++) begin
            ok = (txc == (8'hFF << k)) && (txd[8*k +: 8] == 8'hFD);
            for (int j = 0; j < 8; j++) begin
                ok = ok & ((j <= k) | (txd[8*j +: 8] == 8'h07));
            end
            hit[k] = ok;
        end
        return hit;
    endfunction

    // Lane index of a one-hot terminate match (at most one bit can be set).
    function automatic logic [2:0] onehot_idx(input logic [7:0] hit);
        logic [2:0] idx;
        case (hit)
            8'b0000_0001: idx = 3'd0;
            8'b0000_0010: idx = 3'd1;
            8'b0000_0100: idx = 3'd2;
            8'b0000_1000: idx = 3'd3;
            8'b0001_0000: idx = 3'd4;
            8'b0010_0000: idx = 3'd5;
            8'b0100_0000: idx = 3'd6;
            8'b1000_0000: idx = 3'd7;
            default:      idx = 3'd0;
        endcase
        return idx;
    endfunction

    // Block type field for a terminate in lane k.
    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        case (k)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            3'd7:    t = 8'hFF;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

    // Terminate block: data lanes below k packed from bit 8, everything
    // above (pad bits and idle codes) is zero.
    function automatic logic [63:0] term_block(input logic [63:0] txd,
                                               input logic [2:0]  k);
        logic [63:0] mask;
        mask = ~(64'hFFFF_FFFF_FFFF_FFFF << {k, 3'b000});
        return ((txd & mask) << 4'd8) | {56'h0, term_type(k)};
    endfunction

    // Error block: control type with eight /E/ (0x1E) 7-bit codes.
    function automatic logic [63:0] err_block();
        logic [63:0] b;
        b = {56'h0, 8'h1E};
        for (int i = 0; i < 8; i++) begin
            b[8 + 7*i +: 7] = 7'h1E;
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Input word pairing
    // ------------------------------------------------------------------
    logic                  phase_q;
    logic [DATA_WIDTH-1:0] txd0_q;
    logic [CTRL_WIDTH-1:0] txc0_q;
    logic                  blk_done_s;

    assign blk_done_s = i_xgmii_valid & phase_q;

    // Track word phase and hold the lanes 0-3 word until its partner arrives.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            phase_q <= 1'b0;
            txd0_q  <= {DATA_WIDTH{1'b0}};
            txc0_q  <= {CTRL_WIDTH{1'b0}};
        end else if (i_xgmii_valid) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                txd0_q <= i_xgmii_txd;
                txc0_q <= i_xgmii_txc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Classification and encoding of the block being completed
    // ------------------------------------------------------------------
    logic [BLK_W-1:0] blk_txd_s;
    logic [BLK_C-1:0] blk_txc_s;
    logic [7:0]       term_hit_s;
    logic [2:0]       t_k_s;
    cls_t             cls_s;
    logic [BLK_W-1:0] enc_s;

    // Classify the assembled 8-lane block.
    always_comb begin
        blk_txd_s  = {i_xgmii_txd, txd0_q};
        blk_txc_s  = {i_xgmii_txc, txc0_q};
        term_hit_s = term_lanes(blk_txd_s, blk_txc_s);
        t_k_s      = onehot_idx(term_hit_s);
        if (blk_txc_s == 8'h00) begin
            cls_s = CLS_D;
        end else if ((blk_txc_s == 8'hFF) &&
                     (blk_txd_s == 64'h0707_0707_0707_0707)) begin
            cls_s = CLS_C;
        end else if ((blk_txc_s == 8'h01) && (blk_txd_s[7:0] == 8'hFB)) begin
            cls_s = CLS_S0;
        end else if ((blk_txc_s == 8'h1F) &&
                     (blk_txd_s[31:0] == 32'h0707_0707) &&
                     (blk_txd_s[39:32] == 8'hFB)) begin
            cls_s = CLS_S4;
        end else if (term_hit_s != 8'h00) begin
            cls_s = CLS_T;
        end else begin
            cls_s = CLS_ERR;
        end
    end

    // Build the 64-bit block payload for the detected class.
    always_comb begin
        enc_s = err_block();
        case (cls_s)
            CLS_D:   enc_s = blk_txd_s;
            CLS_C:   enc_s = {56'h0, 8'h1E};
            CLS_S0:  enc_s = {blk_txd_s[63:8], 8'h78};
            CLS_S4:  enc_s = {blk_txd_s[63:40], 32'h0, 8'h33};
            CLS_T:   enc_s = term_block(blk_txd_s, t_k_s);
            default: enc_s = err_block();
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit sequence check
    // ------------------------------------------------------------------
    tx_state_t              state_q;
    tx_state_t              state_d;
    logic                   emit_ok_s;
    logic [BLK_W-1:0]       blk_d;
    logic [HDR_WIDTH-1:0]   hdr_d;
    logic [DATA_WIDTH-1:0]  word1_q;
    logic                   word1_pend_q;

    // Decide whether the block is legal in the current state and what follows.
    always_comb begin
        state_d   = state_q;
        emit_ok_s = 1'b0;
        case (state_q)
            TX_C: begin
                case (cls_s)
                    CLS_C: begin
                        emit_ok_s = 1'b1;
                        state_d   = TX_C;
                    end
                    CLS_S0, CLS_S4: begin
                        emit_ok_s = 1'b1;
                        state_d   = TX_D;
                    end
                    default: begin
                        emit_ok_s = 1'b0;
                        state_d   = TX_E;
                    end
                endcase
            end
            TX_D: begin
                case (cls_s)
                    CLS_D: begin
                        emit_ok_s = 1'b1;
                        state_d   = TX_D;
                    end
                    CLS_T: begin
                        emit_ok_s = 1'b1;
                        state_d   = TX_C;
                    end
                    default: begin
                        emit_ok_s = 1'b0;
                        state_d   = TX_E;
                    end
                endcase
            end
            TX_E: begin
                case (cls_s)
                    CLS_C, CLS_T: begin
                        emit_ok_s = 1'b1;
                        state_d   = TX_C;
                    end
                    CLS_S0, CLS_S4, CLS_D: begin
                        emit_ok_s = 1'b1;
                        state_d   = TX_D;
                    end
                    default: begin
                        emit_ok_s = 1'b0;
                        state_d   = TX_E;
                    end
                endcase
            end
            default: begin
                emit_ok_s = 1'b0;
                state_d   = TX_C;
            end
        endcase
        if (emit_ok_s) begin
            blk_d = enc_s;
            hdr_d = (cls_s == CLS_D) ? 2'b01 : 2'b10;
        end else begin
            blk_d = err_block();
            hdr_d = 2'b10;
        end
    end

    // Sequence state and output words: word0 with header on capture, word1 next.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q         <= TX_C;
            o_tx_data       <= {DATA_WIDTH{1'b0}};
            o_tx_data_valid <= 1'b0;
            o_tx_hdr        <= {HDR_WIDTH{1'b0}};
            o_tx_hdr_valid  <= 1'b0;
            o_encode_err    <= 1'b0;
            word1_q         <= {DATA_WIDTH{1'b0}};
            word1_pend_q    <= 1'b0;
        end else if (blk_done_s) begin
            state_q         <= state_d;
            o_tx_data       <= blk_d[DATA_WIDTH-1:0];
            o_tx_data_valid <= 1'b1;
            o_tx_hdr        <= hdr_d;
            o_tx_hdr_valid  <= 1'b1;
            o_encode_err    <= ~emit_ok_s;
            word1_q         <= blk_d[BLK_W-1:DATA_WIDTH];
            word1_pend_q    <= 1'b1;
        end else if (word1_pend_q) begin
            o_tx_data       <= word1_q;
            o_tx_data_valid <= 1'b1;
            o_tx_hdr_valid  <= 1'b0;
            o_encode_err    <= 1'b0;
            word1_pend_q    <= 1'b0;
        end else begin
            o_tx_data_valid <= 1'b0;
            o_tx_hdr_valid  <= 1'b0;
            o_encode_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xgmii_encoder.sv
// Self-checking bench for xgmii_encoder: directed scenarios plus randomized
// block streams, compared against a lane-level reference model.
module tb_xgmii_encoder;

    localparam int CL_C = 0, CL_S0 = 1, CL_S4 = 2, CL_D = 3, CL_T = 4, CL_INV = 5;
    localparam int ST_C = 0, ST_D = 1, ST_E = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] txd   = 32'h0;
    logic [3:0]  txc   = 4'h0;
    logic        vld   = 1'b0;
    logic [31:0] o_tx_data;
    logic        o_tx_data_valid;
    logic [1:0]  o_tx_hdr;
    logic        o_tx_hdr_valid;
    logic        o_encode_err;

    always #5 clk = ~clk;

    xgmii_encoder dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_xgmii_txd     (txd),
        .i_xgmii_txc     (txc),
        .i_xgmii_valid   (vld),
        .o_tx_data       (o_tx_data),
        .o_tx_data_valid (o_tx_data_valid),
        .o_tx_hdr        (o_tx_hdr),
        .o_tx_hdr_valid  (o_tx_hdr_valid),
        .o_encode_err    (o_encode_err)
    );

    typedef struct {
        logic [1:0]  hdr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        err;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          rst_active = 1'b0;
    bit          mon_w1 = 1'b0;
    logic [31:0] mon_w1_val = 32'h0;
    int          m_phase = 0;
    int          m_st = ST_C;
    logic [31:0] m_txd0 = 32'h0;
    logic [3:0]  m_txc0 = 4'h0;

    // Free-running cycle count used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [7:0] lane(input logic [63:0] d, input int i);
        return d[8*i +: 8];
    endfunction

    function automatic logic [63:0] put(input logic [63:0] b, input int p,
                                        input logic [63:0] v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return b | ((v & m) << p);
    endfunction

    // Block class from the lane contents and control flags.
    function automatic int classify(input logic [63:0] d, input logic [7:0] c, output int k);
        int low;
        bit ok;
        k = 0;
        if (c == 8'h00) return CL_D;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (lane(d, i) != 8'h07) ok = 1'b0;
        if (c == 8'hFF && ok) return CL_C;
        if (c == 8'h01 && lane(d, 0) == 8'hFB) return CL_S0;
        if (c == 8'h1F && lane(d, 4) == 8'hFB && d[31:0] == 32'h07070707) return CL_S4;
        low = 0;
        while (low < 8 && !c[low]) low++;
        ok = (lane(d, low) == 8'hFD);
        for (int i = low; i < 8; i++) begin
            if (!c[i]) ok = 1'b0;
            if (i > low && lane(d, i) != 8'h07) ok = 1'b0;
        end
        if (ok) begin
            k = low;
            return CL_T;
        end
        return CL_INV;
    endfunction

    function automatic logic [7:0] ttype(input int k);
        case (k)
            0: return 8'h87;
            1: return 8'h99;
            2: return 8'hAA;
            3: return 8'hB4;
            4: return 8'hCC;
            5: return 8'hD2;
            6: return 8'hE1;
            default: return 8'hFF;
        endcase
    endfunction

    // Encoded block built field by field from bit 0 upward.
    function automatic logic [63:0] encode(input int cls, input int k, input logic [63:0] d);
        logic [63:0] b;
        int p;
        b = 64'h0;
        p = 0;
        case (cls)
            CL_D: b = d;
            CL_C: begin
                b = put(b, p, 64'h1E, 8); p += 8;
                for (int i = 0; i < 8; i++) begin b = put(b, p, 64'h00, 7); p += 7; end
            end
            CL_S0: begin
                b = put(b, p, 64'h78, 8); p += 8;
                for (int i = 1; i < 8; i++) begin b = put(b, p, 64'(lane(d, i)), 8); p += 8; end
            end
            CL_S4: begin
                b = put(b, p, 64'h33, 8); p += 8;
                for (int i = 0; i < 4; i++) begin b = put(b, p, 64'h00, 7); p += 7; end
                b = put(b, p, 64'h0, 4); p += 4;
                for (int i = 5; i < 8; i++) begin b = put(b, p, 64'(lane(d, i)), 8); p += 8; end
            end
            CL_T: begin
                b = put(b, p, 64'(ttype(k)), 8); p += 8;
                for (int i = 0; i < k; i++) begin b = put(b, p, 64'(lane(d, i)), 8); p += 8; end
                p += 7 - k;
                for (int i = k + 1; i < 8; i++) begin b = put(b, p, 64'h00, 7); p += 7; end
            end
            default: begin
                b = put(b, p, 64'h1E, 8); p += 8;
                for (int i = 0; i < 8; i++) begin b = put(b, p, 64'h1E, 7); p += 7; end
            end
        endcase
        return b;
    endfunction

    // Reference model: pair words into blocks, apply the sequence rules.
    task automatic model_word(input logic [31:0] d, input logic [3:0] c);
        logic [63:0] blk;
        logic [63:0] enc;
        logic [7:0]  cc;
        int          cls, k, nxt;
        bit          ok;
        exp_t        e;
        if (m_phase == 0) begin
            m_txd0  = d;
            m_txc0  = c;
            m_phase = 1;
        end else begin
            blk = {d, m_txd0};
            cc  = {c, m_txc0};
            cls = classify(blk, cc, k);
            case (m_st)
                ST_C: begin
                    ok  = (cls == CL_C) || (cls == CL_S0) || (cls == CL_S4);
                    nxt = (cls == CL_C) ? ST_C : (ok ? ST_D : ST_E);
                end
                ST_D: begin
                    ok  = (cls == CL_D) || (cls == CL_T);
                    nxt = (cls == CL_D) ? ST_D : ((cls == CL_T) ? ST_C : ST_E);
                end
                default: begin
                    ok  = (cls != CL_INV);
                    nxt = (cls == CL_C || cls == CL_T) ? ST_C : (ok ? ST_D : ST_E);
                end
            endcase
            m_st  = nxt;
            enc   = ok ? encode(cls, k, blk) : encode(CL_INV, 0, blk);
            e.hdr = (ok && cls == CL_D) ? 2'b01 : 2'b10;
            e.w0  = enc[31:0];
            e.w1  = enc[63:32];
            e.err = !ok;
            e.due = cyc + 1;
            exp_q.push_back(e);
            m_phase = 0;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] c);
        @(posedge clk); #1;
        txd = d;
        txc = c;
        vld = 1'b1;
        model_word(d, c);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        txd = $urandom;
        txc = 4'($urandom);
        vld = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] d, input logic [7:0] c, input int gap);
        send_word(d[31:0], c[3:0]);
        repeat (gap) idle_cycle();
        send_word(d[63:32], c[7:4]);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n = 1'b0;
        vld   = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        rst_active = 1'b1;
        m_phase    = 0;
        m_st       = ST_C;
        repeat (n) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        rst_active = 1'b0;
    endtask

    task automatic make_block(input int kind, output logic [63:0] d, output logic [7:0] c);
        int k;
        d = {$urandom, $urandom};
        case (kind)
            CL_C:  begin d = 64'h0707070707070707; c = 8'hFF; end
            CL_S0: begin d[7:0] = 8'hFB; c = 8'h01; end
            CL_S4: begin d[39:0] = {8'hFB, 32'h07070707}; c = 8'h1F; end
            CL_D:  c = 8'h00;
            CL_T: begin
                k = $urandom_range(0, 7);
                c = 8'hFF << k;
                d[8*k +: 8] = 8'hFD;
                for (int j = k + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
            end
            default: c = 8'($urandom);
        endcase
    endtask

    // Output monitor: compares each emitted word against the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            if (rst_active) begin
                check_eq("rst_data", 64'(o_tx_data), 64'd0);
                check_eq("rst_hdr", 64'(o_tx_hdr), 64'd0);
                check_eq("rst_dvalid", 64'(o_tx_data_valid), 64'd0);
                check_eq("rst_hvalid", 64'(o_tx_hdr_valid), 64'd0);
                check_eq("rst_err", 64'(o_encode_err), 64'd0);
                mon_w1 = 1'b0;
            end
        end else if (mon_w1) begin
            check_eq("w1_dvalid", 64'(o_tx_data_valid), 64'd1);
            check_eq("w1_hvalid", 64'(o_tx_hdr_valid), 64'd0);
            check_eq("w1_data", 64'(o_tx_data), 64'(mon_w1_val));
            check_eq("w1_err", 64'(o_encode_err), 64'd0);
            mon_w1 = 1'b0;
        end else if (o_tx_data_valid || o_tx_hdr_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 64'({o_tx_data_valid, o_tx_hdr_valid}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("w0_dvalid", 64'(o_tx_data_valid), 64'd1);
                check_eq("w0_hvalid", 64'(o_tx_hdr_valid), 64'd1);
                check_eq("w0_hdr", 64'(o_tx_hdr), 64'(e.hdr));
                check_eq("w0_data", 64'(o_tx_data), 64'(e.w0));
                check_eq("w0_err", 64'(o_encode_err), 64'(e.err));
                check_eq("latency", 64'(cyc), 64'(e.due));
                mon_w1     = 1'b1;
                mon_w1_val = e.w1;
            end
        end else begin
            check_eq("idle_err", 64'(o_encode_err), 64'd0);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check_eq("block_missing", 64'(o_tx_hdr_valid), 64'd1);
                e = exp_q.pop_front();
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        int          kind, r;

        do_reset(3);

        // Idle blocks back-to-back.
        send_block(64'h0707070707070707, 8'hFF, 0);
        send_block(64'h0707070707070707, 8'hFF, 0);

        // Frame: S0, two data blocks, T3 with lanes 0-2 = 0xAA.
        make_block(CL_S0, d, c); send_block(d, c, 0);
        make_block(CL_D, d, c);  send_block(d, c, 0);
        make_block(CL_D, d, c);  send_block(d, c, 0);
        send_block(64'h07070707_FDAAAAAA, 8'hF8, 0);

        // S4 after idle, then data proves the data state was entered.
        send_block(64'h0707070707070707, 8'hFF, 0);
        make_block(CL_S4, d, c); send_block(d, c, 0);
        make_block(CL_D, d, c);  send_block(d, c, 0);
        make_block(CL_T, d, c);  send_block(d, c, 0);

        // Data while idle gives an error block; idle afterwards recovers.
        make_block(CL_D, d, c);  send_block(d, c, 0);
        send_block(64'h0707070707070707, 8'hFF, 0);

        // Valid gaps of three cycles inside blocks.
        make_block(CL_S0, d, c); send_block(d, c, 3);
        make_block(CL_D, d, c);  send_block(d, c, 3);
        make_block(CL_T, d, c);  send_block(d, c, 3);
        repeat (4) idle_cycle();

        // Reset after a phase-0 word, then a fresh block.
        send_word(32'h07070707, 4'hF);
        do_reset(2);
        make_block(CL_S0, d, c); send_block(d, c, 0);

        // Reset right after a block capture discards its output.
        make_block(CL_D, d, c);  send_block(d, c, 0);
        do_reset(2);
        send_block(64'h0707070707070707, 8'hFF, 0);

        // Randomized block stream, mostly legal sequences with some noise.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                kind = $urandom_range(0, 5);
            end else begin
                case (m_st)
                    ST_C:    kind = (r < 70) ? CL_C : ((r < 85) ? CL_S0 : CL_S4);
                    ST_D:    kind = (r < 80) ? CL_D : CL_T;
                    default: kind = $urandom_range(0, 4);
                endcase
            end
            make_block(kind, d, c);
            send_block(d, c, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) idle_cycle();
            end
        end

        repeat (6) idle_cycle();
        check_eq("drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/xgmii_encoder.md
XGMII_ENCODER -- requirements
Module: xgmii_encoder

Interface
REQ-001 Parameters, one per line: DATA_WIDTH, 32, word width; HDR_WIDTH, 2, sync header width; CTRL_WIDTH, 4, XGMII control lanes per word.
REQ-002 i_clk  input  1  clock; all logic SHALL be single-edge, rising.
REQ-003 i_reset_n  input  1  reset; synchronous, active-low.
REQ-004 i_xgmii_txd  input  32  XGMII data from MAC; lane k = bits [8k+7:8k].
REQ-005 i_xgmii_txc  input  4  XGMII control flags; bit k set = lane k is a control character.
REQ-006 i_xgmii_valid  input  1  input word qualifier.
REQ-007 o_tx_data  output  32  encoded block word to scrambler.
REQ-008 o_tx_data_valid  output  1  o_tx_data qualifier.
REQ-009 o_tx_hdr  output  2  sync header (01 data, 10 control).
REQ-010 o_tx_hdr_valid  output  1  high only on the first word of each block.
REQ-011 o_encode_err  output  1  one-cycle pulse when an error block is emitted.

Function
REQ-012 Input phase bit SHALL toggle on each i_xgmii_valid cycle; phase 0 word = lanes 0-3, phase 1 word = lanes 4-7 of one 8-lane block; phase held while i_xgmii_valid low.
REQ-013 Phase-0 word SHALL be registered; on the phase-1 valid cycle the 64-bit block SHALL be classified, encoded and registered with its header.
REQ-014 Output word0 (block bits [31:0], o_tx_hdr_valid=1) SHALL appear the cycle after phase-1 capture; word1 (bits [63:32], o_tx_hdr_valid=0) the following cycle; o_tx_data_valid high both cycles, low otherwise; back-to-back input gives 2-cycle latency per word.
REQ-015 Classification: D = txc 0x00; C = txc 0xFF, all lanes 0x07; S0 = txc 0x01, lane0 0xFB; S4 = txc 0x1F, lanes0-3 0x07, lane4 0xFB; Tk (k=0..7) = lane k 0xFD, lanes <k data, lanes >k 0x07, txc bits >=k set; anything else = invalid.
REQ-016 D block: hdr 01, payload = 8 lanes unchanged.
REQ-017 C block: hdr 10, type 0x1E, eight 7-bit codes 0x00 in bits [63:8].
REQ-018 S0: hdr 10, type 0x78, lanes1-7 in bits [63:8].
REQ-019 S4: hdr 10, type 0x33, four 7-bit 0x00 codes in [35:8], bits [39:36]=0, lanes5-7 in [63:40].
REQ-020 Tk: hdr 10, type 0x87/99/AA/B4/CC/D2/E1/FF for k=0..7; lanes 0..k-1 from bit 8 up; (7-k) zero pad bits; (7-k) 7-bit 0x00 codes in the top bits.
REQ-021 Error block: hdr 10, type 0x1E, eight 7-bit codes 0x1E; o_encode_err pulses with its word0.
REQ-022 Sequence FSM states TX_C, TX_D, TX_E, evaluated per completed block:
REQ-023 TX_C: C -> emit C, stay; S0/S4 -> emit S, TX_D; D/T/invalid -> emit error, TX_E.
REQ-024 TX_D: D -> emit D, stay; T -> emit T, TX_C; C/S/invalid -> emit error, TX_E.
REQ-025 TX_E: C -> TX_C; S or D -> TX_D; T -> TX_C; each emitted normally; invalid -> emit error, stay.
REQ-026 Partial block (phase 1 pending) SHALL never be emitted; it completes on the next valid word.

Reset
REQ-027 While i_reset_n low: phase 0, FSM TX_C, o_tx_data 0, o_tx_hdr 00, all valid outputs and o_encode_err 0.
REQ-028 Reset mid-block or mid-output SHALL discard the pending word/block; first post-reset valid word is phase 0.

Verification
REQ-029 Idle: txd 0x07070707 txc 0xF x2 -> hdr 10, word0 0x0000001E, word1 0x00000000, hdr_valid on word0 only.
REQ-030 Frame S0, 2 D blocks, T3 (lanes0-2 0xAA) back-to-back -> headers 10,01,01,10; T word0 0x AAAAAA B4? i.e. {0xAA,0xAA,0xAA,0xB4}, word1 0x00000000; 2-cycle latency.
REQ-031 S4 after idle -> type 0x33, bits [39:36]=0, lanes5-7 in [63:40]; FSM enters TX_D.
REQ-032 D block while TX_C -> error block type 0x1E, codes 0x1E, o_encode_err one pulse; subsequent C -> normal idle block.
REQ-033 i_xgmii_valid gaps of 3 cycles between phase 0 and phase 1 -> single correct block, no output during gap.
REQ-034 Reset asserted after phase-0 word -> no output; next two valid words form a fresh block.
